// File: rtl/led_ctrl_pkg.sv
// Shared types, seeds and pattern stepping for the LED pattern controller.
// Imported by the tick generator and the top-level sequencer.
package led_ctrl_pkg;

  localparam int LED_W = 6;

  typedef enum logic [1:0] {
    FLOW_L = 2'd0,
    FLOW_R = 2'd1,
    BOUNCE = 2'd2,
    BLINK  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1,
    LOAD   = 2'd2
  } state_t;

  localparam logic [LED_W-1:0] SEED_FLOW_L = 6'b000001;
  localparam logic [LED_W-1:0] SEED_FLOW_R = 6'b100000;
  localparam logic [LED_W-1:0] SEED_BOUNCE = 6'b000001;
  localparam logic [LED_W-1:0] SEED_BLINK  = 6'b111111;

  function automatic logic [LED_W-1:0] seed_of(mode_t m);
    logic [LED_W-1:0] s;
    s = SEED_FLOW_L;
    unique case (m)
      FLOW_L: s = SEED_FLOW_L;
      FLOW_R: s = SEED_FLOW_R;
      BOUNCE: s = SEED_BOUNCE;
      BLINK:  s = SEED_BLINK;
      default: s = SEED_FLOW_L;
    endcase
    return s;
  endfunction

  // dir_right selects the BOUNCE travel direction (0 = toward bit5)
  function automatic logic [LED_W-1:0] step_led(
    mode_t            m,
    logic [LED_W-1:0] l,
    logic             dir_right
  );
    logic [LED_W-1:0] n;
    n = l;
    unique case (m)
      FLOW_L: n = {l[LED_W-2:0], l[LED_W-1]};
      FLOW_R: n = {l[0], l[LED_W-1:1]};
      BOUNCE: n = dir_right ? (l >> 1) : (l << 1);
      BLINK:  n = ~l;
      default: n = l;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/led_pattern_ctrl_tick.sv
// Step-period counter: counts 0..TICK_MAX while enabled, flags the wrap.
// Clear has priority over enable.
module led_tick_gen
  import led_ctrl_pkg::*;
#(
  parameter int TICK_MAX = 9_000_000,
  parameter int CNT_W    = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  logic [CNT_W-1:0] cnt;
  logic             at_max;

  assign at_max = (cnt == CNT_W'(TICK_MAX));
  assign wrap   = en && at_max;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_max ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern sequencer: mode handshake, pause control and pattern register.
// Single driver of the LED bank.
module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int TICK_MAX = 9_000_000,
  parameter int CNT_W    = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             mode_req_valid,
  input  logic [1:0]       mode_req,
  output logic             mode_req_ready,
  input  logic             pause,
  output logic [LED_W-1:0] led,
  output logic [1:0]       mode,
  output logic             tick
);

  state_t           state;
  mode_t            mode_r;
  logic             dir_right;
  logic             accept;
  logic             wrap;
  logic             en;
  logic             clr;
  logic [LED_W-1:0] nxt_led;

  assign mode_req_ready = (state != LOAD);
  assign accept         = mode_req_valid && mode_req_ready;
  // an accepted request swallows a step due on the same edge
  assign en             = (state == RUN) && !accept;
  assign clr            = accept || (state == LOAD);
  assign nxt_led        = step_led(mode_r, led, dir_right);
  assign mode           = mode_r;

  led_tick_gen #(
    .TICK_MAX(TICK_MAX),
    .CNT_W   (CNT_W)
  ) u_tick (
    .clk  (sys_clk),
    .rst_n(sys_rst_n),
    .en   (en),
    .clr  (clr),
    .wrap (wrap)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state     <= RUN;
      mode_r    <= FLOW_L;
      led       <= SEED_FLOW_L;
      dir_right <= 1'b0;
      tick      <= 1'b0;
    end else begin
      tick <= 1'b0;
      unique case (state)
        LOAD: begin
          led       <= seed_of(mode_r);
          dir_right <= 1'b0;
          state     <= pause ? PAUSED : RUN;
        end
        RUN, PAUSED: begin
          if (accept) begin
            mode_r <= mode_t'(mode_req);
            state  <= LOAD;
          end else begin
            if (wrap) begin
              led  <= nxt_led;
              tick <= 1'b1;
              if (mode_r == BOUNCE) begin
                if (!dir_right && nxt_led[LED_W-1])
                  dir_right <= 1'b1;
                else if (dir_right && nxt_led[0])
                  dir_right <= 1'b0;
              end
            end
            if (state == RUN && pause)
              state <= PAUSED;
            else if (state == PAUSED && !pause)
              state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl with TICK_MAX=3.
// Directed scenarios with literal checks, then randomized traffic vs. model.
module tb_led_pattern_ctrl;

  localparam int TM = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [1:0] req = 2'd0;
  logic       pause = 1'b0;
  logic       ready;
  logic [5:0] led;
  logic [1:0] mode;
  logic       tick;

  int n_vec = 0;
  int n_err = 0;

  led_pattern_ctrl #(
    .TICK_MAX(TM),
    .CNT_W   (32)
  ) u_dut (
    .sys_clk       (clk),
    .sys_rst_n     (rst_n),
    .mode_req_valid(valid),
    .mode_req      (req),
    .mode_req_ready(ready),
    .pause         (pause),
    .led           (led),
    .mode          (mode),
    .tick          (tick)
  );

  always #5 clk = ~clk;

  // pattern value after k steps from the seed of mode m
  function automatic logic [5:0] pat(int m, int k);
    int p;
    logic [5:0] r;
    r = 6'd0;
    case (m)
      0: r = 6'(1 << (k % 6));
      1: r = 6'(32 >> (k % 6));
      2: begin
        p = k % 10;
        r = 6'(1 << ((p <= 5) ? p : 10 - p));
      end
      default: r = (k % 2 == 1) ? 6'd0 : 6'd63;
    endcase
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: phase 0 running, 1 paused, 2 loading the seed
  int         m_mode, m_k, m_cnt, m_ph;
  logic [5:0] m_led;
  logic       m_tick;
  bit         m_ok = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_k = 0; m_cnt = 0; m_ph = 0;
      m_led = pat(0, 0); m_tick = 1'b0; m_ok = 1;
    end else begin
      m_tick = 1'b0;
      if (m_ph == 2) begin
        m_cnt = 0; m_k = 0;
        m_led = pat(m_mode, 0);
        m_ph = pause ? 1 : 0;
      end else if (valid) begin
        m_mode = int'(req);
        m_ph = 2;
      end else if (m_ph == 0) begin
        if (m_cnt == TM) begin
          m_cnt = 0; m_k++;
          m_led = pat(m_mode, m_k);
          m_tick = 1'b1;
        end else begin
          m_cnt++;
        end
        if (pause) m_ph = 1;
      end else if (!pause) begin
        m_ph = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("led", 32'(led), 32'(m_led));
      chk("mode", 32'(mode), 32'(m_mode));
      chk("tick", 32'(tick), 32'(m_tick));
      chk("ready", 32'(ready), 32'(m_ph != 2));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  logic [5:0] bseq [10] = '{6'd2, 6'd4, 6'd8, 6'd16, 6'd32,
                            6'd16, 6'd8, 6'd4, 6'd2, 6'd1};

  initial begin
    repeat (2) cyc();
    chk("rst_led", 32'(led), 32'h01);
    chk("rst_mode", 32'(mode), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_ready", 32'(ready), 32'h1);
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("run_hold", 32'(led), 32'h01);
    cyc();
    chk("run_step1", 32'(led), 32'h02);
    chk("run_tick1", 32'(tick), 32'h1);
    repeat (4) cyc();
    chk("run_step2", 32'(led), 32'h04);

    // BOUNCE
    valid = 1'b1; req = 2'd2;
    chk("bnc_ready", 32'(ready), 32'h1);
    cyc();
    valid = 1'b0;
    chk("bnc_mode", 32'(mode), 32'h2);
    chk("bnc_load_rdy", 32'(ready), 32'h0);
    chk("bnc_led_held", 32'(led), 32'h04);
    cyc();
    chk("bnc_seed", 32'(led), 32'h01);
    for (int i = 0; i < 10; i++) begin
      repeat (4) cyc();
      chk("bnc_step", 32'(led), 32'(bseq[i]));
    end

    // collision: accept while counter is at TICK_MAX
    repeat (3) cyc();
    valid = 1'b1; req = 2'd3;
    cyc();
    valid = 1'b0;
    chk("col_notick", 32'(tick), 32'h0);
    chk("col_led", 32'(led), 32'h01);
    cyc();
    chk("col_seed", 32'(led), 32'h3f);
    repeat (4) cyc();
    chk("col_step", 32'(led), 32'h00);
    chk("col_tick", 32'(tick), 32'h1);

    // pause in FLOW_R, then request while paused
    valid = 1'b1; req = 2'd1;
    cyc();
    valid = 1'b0;
    cyc();
    chk("fr_seed", 32'(led), 32'h20);
    repeat (2) cyc();
    pause = 1'b1;
    cyc();
    repeat (20) cyc();
    chk("pz_led", 32'(led), 32'h20);
    chk("pz_cnt", 32'(u_dut.u_tick.cnt), 32'h3);
    valid = 1'b1; req = 2'd1;
    chk("pz_ready", 32'(ready), 32'h1);
    cyc();
    valid = 1'b0;
    chk("pz_load_rdy", 32'(ready), 32'h0);
    cyc();
    chk("pz_seed", 32'(led), 32'h20);
    chk("pz_rdy_back", 32'(ready), 32'h1);
    repeat (3) cyc();
    chk("pz_still", 32'(led), 32'h20);
    chk("pz_cnt0", 32'(u_dut.u_tick.cnt), 32'h0);
    pause = 1'b0;
    cyc();
    repeat (4) cyc();
    chk("pz_resume", 32'(led), 32'h10);

    // reset during BLINK
    valid = 1'b1; req = 2'd3;
    cyc();
    valid = 1'b0;
    repeat (6) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("mr_led", 32'(led), 32'h01);
    chk("mr_mode", 32'(mode), 32'h0);
    chk("mr_cnt", 32'(u_dut.u_tick.cnt), 32'h0);
    chk("mr_tick", 32'(tick), 32'h0);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      valid = ($urandom_range(0, 9) == 0);
      req   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) pause = ~pause;
      cyc();
    end
    rst_n = 1'b1; valid = 1'b0; pause = 1'b0;
    repeat (4) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Pattern sequencer and mode controller for the 6-bit board LED bank. It owns the tick counter and the LED shift register and runs one of four display patterns. It accepts mode-change requests over a valid/ready handshake and supports a pause input. It sits between the key/UART command logic and the LED pins, and is the single driver of `led`.

## Interface
- `TICK_MAX`, default 9_000_000: tick counter terminal value; pattern period = TICK_MAX+1 clocks per step.
- `CNT_W`, default 32: tick counter width; must satisfy TICK_MAX < 2^CNT_W.
- `sys_clk`  in  1  system clock; the block's only clock.
- `sys_rst_n`  in  1  reset; synchronous, active-low.
- `mode_req_valid`  in  1  mode-change request valid.
- `mode_req`  in  2  requested mode: 0 FLOW_L, 1 FLOW_R, 2 BOUNCE, 3 BLINK.
- `mode_req_ready`  out  1  request accepted on cycles where valid && ready.
- `pause`  in  1  level; freezes pattern while high.
- `led`  out  6  LED drive, active-high.
- `mode`  out  2  currently running mode.
- `tick`  out  1  one-cycle pulse on each pattern step.

## Operation
- FSM states: RUN, PAUSED, LOAD.
- **RUN**
  - Counter increments each clock.
  - At TICK_MAX it wraps to 0, steps the pattern and pulses `tick`.
  - `pause`=1 → PAUSED.
- **PAUSED**
  - Counter, `led` and the direction flag hold; `tick`=0.
  - `pause`=0 → RUN; the counter resumes from its held value.
- **LOAD** (one cycle)
  - Counter=0; `led`=seed of the new mode; direction flag=left.
  - Exit to PAUSED if `pause`=1, else RUN.
- **Handshake**
  - `mode_req_ready`=1 in RUN and PAUSED, 0 in LOAD.
  - Acceptance registers `mode_req` into `mode` and enters LOAD.
  - A request for the current mode is still accepted and restarts that mode from its seed.
  - `mode_req` is sampled only on the accept cycle.
- **Patterns** (step = one tick)
  - FLOW_L: seed 000001; `led` ← {led[4:0],led[5]}.
  - FLOW_R: seed 100000; `led` ← {led[0],led[5:1]}.
  - BOUNCE: seed 000001, dir=left.
    - Left: shift left (zero fill). Right: shift right (zero fill).
    - Direction flips on the step that lands on bit5 or bit0.
    - Sequence 000001→000010→…→100000→010000→…→000001, period 10 ticks.
  - BLINK: seed 111111; `led` ← ~`led`.
- **Priority** in a given cycle:
  - Reset over accept.
  - Accept over tick step: a request accepted in the same cycle as the counter reaching TICK_MAX produces no step and no `tick`.
  - Accept over pause: request taken in PAUSED.
- **Reset values**: `led`=000001, `mode`=0 (FLOW_L), state=RUN, counter=0, dir=left, `tick`=0, `mode_req_ready`=1.
- Reset asserted mid-pattern or in LOAD returns all of the above on the next edge; pending requests are dropped.

## Timing
- All outputs are registered except `mode_req_ready`, which is decoded from state.
- Step latency: the edge that wraps the counter TICK_MAX→0 also updates `led`, and `tick`=1 for the following cycle. `tick` and the new `led` are visible together.
- First step after reset: `led` changes after TICK_MAX+1 clocks (edge TICK_MAX+1 counting the reset-release edge as 0).
- Mode change:
  - Accept at edge N: `mode` updates and state=LOAD at N.
  - Seed on `led` at N+1; RUN at N+1.
  - First step of the new mode at N+1+TICK_MAX+1.
- Pause: takes effect the edge after `pause` rises. A tick due on that same edge still occurs.

## Structure
- Package `led_ctrl_pkg` holds:
  - mode encoding constants (FLOW_L/FLOW_R/BOUNCE/BLINK);
  - state encoding (RUN/PAUSED/LOAD);
  - seed constants SEED_FLOW_L=6'b000001, SEED_FLOW_R=6'b100000, SEED_BOUNCE=6'b000001, SEED_BLINK=6'b111111;
  - LED_W=6.
- Sub-module `led_tick_gen` holds the counter, with inputs `en` and `clr` and a `wrap` output. The top-level instantiates it and holds the FSM and pattern register.

## Test plan
All scenarios use TICK_MAX=3, i.e. 4 clocks per step.
- **Reset then run**: release reset, hold no requests → `led` 000001, then 000010 at the 4th edge, 000100 at the 8th; `tick` pulses every 4 cycles.
- **BOUNCE mode**: request mode=2 → ready seen; `led`=000001 after LOAD; steps 000010…100000, then 010000; after 10 ticks back at 000001.
- **Pause**: assert `pause` for 20 cycles mid-FLOW_R → `led` and counter frozen, no `tick`; on release, the next step follows the remaining count.
- **Collision**: accept request mode=3 on the cycle the counter equals 3 → no `tick`, `led`=111111 next cycle, then 000000 after 4 more clocks.
- **Request while paused**: in PAUSED, request mode=1 → `led`=100000 and the block stays PAUSED. `mode_req_ready` is low exactly one cycle (LOAD).
- **Reset mid-operation**: assert `sys_rst_n`=0 for one edge during BLINK → next cycle `led`=000001, `mode`=0, counter=0.
